atom_ps2_keyboard: RTL and testbench
====================================

// Module: atom_ps2_keyboard
// PURPOSE
//  Responder side of the Atom PIA keyboard scan. Receives PS/2 scan codes and keeps a
//  10x6 key matrix. Returns active-low column bits for the row the CPU selects on PIA
//  port A[3:0]. Drives PB[5:0] (keyboard), shift_n, ctrl_n and rept_n in place of the
//  tied-high stubs in the top level. All logic runs on the CPU clock.
// PARAMETERS
//  CLKSPEED    25000000  clk frequency in Hz; sets the timeout length
//  TIMEOUT_US  200       idle time in the middle of a frame before the frame is discarded
//  FILTER_LEN  8         cycles ps2_clk must be stable before an edge is accepted
// PORTS
//  clk        in   1  system clock
//  reset_n    in   1  asynchronous, active-low reset
//  ps2_clk    in   1  PS/2 clock (asynchronous; double-synchronised internally)
//  ps2_data   in   1  PS/2 data (asynchronous; double-synchronised internally)
//  row        in   4  row select, from PIA port A[3:0]
//  keyboard   out  6  active-low column bits for the selected row, to PIA port B[5:0]
//  shift_n    out  1  low while either SHIFT key is held
//  ctrl_n     out  1  low while either CTRL key is held
//  rept_n     out  1  low while ALT (REPT) is held
//  frame_err  out  1  one-cycle pulse on a parity, start or stop error, or a timeout
//  break_n    out  1  active-low BREAK request (see CONFIGURATION)
// BEHAVIOUR
//  Reset: matrix cleared; keyboard=6'h3F; shift_n=ctrl_n=rept_n=break_n=1; frame_err=0;
//   receiver in IDLE; E0 and F0 prefix flags cleared. Reset mid-frame drops the frame.
//  Edge detect: filtered ps2_clk level changes only after FILTER_LEN identical samples.
//   ps2_data is sampled on the cycle the filtered falling edge is accepted.
//  Receiver FSM: IDLE -> START (data=0) -> DATA (8 bits, LSB first, 3-bit counter) -> PARITY
//   -> STOP (data=1) -> IDLE.
//   - Start bit = 1: stay in IDLE, no error.
//   - Parity must be odd over data+parity. Stop bit must be 1.
//   - Any failure: discard the byte, pulse frame_err, go to IDLE.
//   - No falling edge for TIMEOUT_US*CLKSPEED/1e6 cycles outside IDLE: go to IDLE and
//     pulse frame_err. The timeout counter reloads on every accepted edge.
//  A good byte is valid one cycle after STOP. Decoder handling:
//   - F0 sets brk; E0 sets ext.
//   - Any other code is looked up as {ext,code} and updates the target: set if !brk,
//     clear if brk. Then brk and ext both clear. Unmapped codes only clear the flags.
//   - A repeated make on a set key leaves it set.
//  Map (fixed): 0x12/0x59 shift; 0x14 and E0 0x14 ctrl; 0x11 and E0 0x11 rept;
//   0x1C 'A' -> row1 col3; 0x29 SPACE -> row9 col0; 0x5A RETURN -> row6 col1;
//   0x76 ESC -> row0 col5; the remaining Atom keys are in the kbd_map function of this file.
//  Read path: keyboard = ~matrix[row] for row 0..9; 6'h3F for row 10..15. The output is
//   combinational from registered state, so a row change is seen in the same cycle.
//  Matrix write takes priority over nothing; there is only one writer per cycle. A row
//   change in the same cycle as a matrix update returns the new row's post-update bits
//   from the next cycle.
// CONFIGURATION
//  ATOM_KBD_BREAK_EN defined:
//   - F12 (0x07) make drives break_n low; break drives it high.
//   - break_n is registered and also forced high by reset_n.
//  Not defined:
//   - break_n is tied to 1.
//   - 0x07 is treated as unmapped.
// TESTING
//  1. Frame 0x1C, then F0 1C; row=1 -> keyboard 6'h37 after the first frame,
//     6'h3F after F0 1C; row=2 -> 6'h3F throughout.
//  2. 0x12, then 0x1C, then F0 12 -> shift_n=0 while held; row1 col3 stays low after
//     shift is released.
//  3. Frame 0x29 with even parity -> frame_err pulses once; row9 stays 6'h3F; the next
//     good 0x29 sets col0 (6'h3E).
//  4. Stop clocking after 4 data bits, wait TIMEOUT+10 cycles -> frame_err pulses; the next
//     full 0x5A frame gives row6 = 6'h3D.
//  5. E0 14, then F0 14 (plain) -> ctrl_n 1->0->1. Glitches on ps2_clk shorter than
//     FILTER_LEN are ignored. Assert reset_n low mid-frame -> all outputs at reset values.
//  6. With ATOM_KBD_BREAK_EN: 0x07 -> break_n=0; F0 07 -> break_n=1. Without the macro,
//     break_n stays 1.

Source files
------------

// File: rtl/atom_ps2_keyboard.sv
// atom_ps2_keyboard
//   PS/2 keyboard front end for the Atom PIA keyboard scan. Receives PS/2 scan
//   codes, keeps a 10x6 key matrix and returns active-low column bits for the
//   row the CPU selects on PIA port A[3:0]. Everything runs on the CPU clock.
//
// Parameters
//   CLKSPEED    clk frequency in Hz (sets the frame timeout length)
//   TIMEOUT_US  idle time inside a frame before the frame is discarded
//   FILTER_LEN  cycles ps2_clk must be stable before an edge is accepted
//
// Ports
//   clk        in   system (CPU) clock
//   reset_n    in   asynchronous active-low reset
//   ps2_clk    in   PS/2 clock, asynchronous
//   ps2_data   in   PS/2 data, asynchronous
//   row        in   [3:0] row select from PIA port A
//   keyboard   out  [5:0] active-low column bits for the selected row
//   shift_n    out  low while either SHIFT key is held
//   ctrl_n     out  low while either CTRL key is held
//   rept_n     out  low while ALT (REPT) is held
//   frame_err  out  one-cycle pulse on parity/start/stop error or timeout
//   break_n    out  active-low BREAK request
//
// Configuration
//   ATOM_KBD_BREAK_EN  when defined, F12 (0x07) drives break_n low while held.
//                      When undefined, break_n is tied high and 0x07 is unmapped.

module atom_ps2_keyboard #(
    parameter int CLKSPEED   = 25000000,
    parameter int TIMEOUT_US = 200,
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] row,
    output logic [5:0] keyboard,
    output logic       shift_n,
    output logic       ctrl_n,
    output logic       rept_n,
    output logic       frame_err,
    output logic       break_n
);
    localparam longint TIMEOUT_CYC = (longint'(TIMEOUT_US) * longint'(CLKSPEED)) / 64'd1000000;
    localparam int     TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int     FW          = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {K_NONE, K_MATRIX, K_SHIFT, K_CTRL, K_REPT, K_BREAK} key_kind_e;
    typedef struct packed {
        key_kind_e  kind;
        logic [3:0] row;
        logic [2:0] col;
    } key_t;

    // ---------------- synchronisers and ps2_clk glitch filter ----------------
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_q;
    logic          differ, settle, fall, dat;

    assign differ = clk_sync_q[1] != filt_q;
    assign settle = differ && (filt_cnt_q == FW'(FILTER_LEN - 1));
    assign fall   = settle && filt_q;
    assign dat    = dat_sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_cnt_q <= '0;
            filt_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop in the chain samples
            // the value from before the edge; blocking would collapse the stages.
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            if (!differ) begin
                filt_cnt_q <= '0;
            end else if (settle) begin
                filt_q     <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- receiver FSM ----------------
    // The start bit is consumed by the IDLE state; RX_DATA collects bits 0..7.
    rx_state_e     rx_state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    sr_q, byte_q;
    logic [TO_W-1:0] to_cnt_q;
    logic          byte_valid_q, frame_err_q, timeout;

    assign timeout = (rx_state_q != RX_IDLE) && !fall && (to_cnt_q == TO_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q   <= RX_IDLE;
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            byte_q       <= '0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fall)
                to_cnt_q <= TO_W'(TIMEOUT_CYC);
            else if (rx_state_q != RX_IDLE && to_cnt_q != '0)
                to_cnt_q <= to_cnt_q - 1'b1;

            if (timeout) begin
                rx_state_q  <= RX_IDLE;
                frame_err_q <= 1'b1;
            end else if (fall) begin
                case (rx_state_q)
                    RX_IDLE: if (!dat) begin
                        rx_state_q <= RX_DATA;
                        bit_cnt_q  <= '0;
                    end
                    RX_DATA: begin
                        sr_q      <= {dat, sr_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) rx_state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        if (^{sr_q, dat}) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_state_q  <= RX_IDLE;
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        rx_state_q <= RX_IDLE;
                        if (dat) begin
                            byte_valid_q <= 1'b1;
                            byte_q       <= sr_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- scan code map ----------------
    function automatic key_t kbd_map(input logic [8:0] code);
        key_t k;
        // NOTE: every field gets a default first so no path leaves anything
        // unassigned (in always_comb that would infer a latch).
        k = '{kind: K_MATRIX, row: 4'd0, col: 3'd0};
        case (code)
            9'h012, 9'h059: k.kind = K_SHIFT;
            9'h014, 9'h114: k.kind = K_CTRL;
            9'h011, 9'h111: k.kind = K_REPT;
`ifdef ATOM_KBD_BREAK_EN
            9'h007:         k.kind = K_BREAK;
`endif
            9'h076: {k.row, k.col} = {4'd0, 3'd5};  9'h015: {k.row, k.col} = {4'd0, 3'd4};
            9'h034: {k.row, k.col} = {4'd0, 3'd3};  9'h04E: {k.row, k.col} = {4'd0, 3'd2};
            9'h026: {k.row, k.col} = {4'd0, 3'd1};
            9'h01A: {k.row, k.col} = {4'd1, 3'd5};  9'h04D: {k.row, k.col} = {4'd1, 3'd4};
            9'h01C: {k.row, k.col} = {4'd1, 3'd3};  9'h041: {k.row, k.col} = {4'd1, 3'd2};
            9'h01E: {k.row, k.col} = {4'd1, 3'd1};
            9'h035: {k.row, k.col} = {4'd2, 3'd5};  9'h044: {k.row, k.col} = {4'd2, 3'd4};
            9'h024: {k.row, k.col} = {4'd2, 3'd3};  9'h04C: {k.row, k.col} = {4'd2, 3'd2};
            9'h016: {k.row, k.col} = {4'd2, 3'd1};  9'h175: {k.row, k.col} = {4'd2, 3'd0};
            9'h022: {k.row, k.col} = {4'd3, 3'd5};  9'h031: {k.row, k.col} = {4'd3, 3'd4};
            9'h023: {k.row, k.col} = {4'd3, 3'd3};  9'h052: {k.row, k.col} = {4'd3, 3'd2};
            9'h045: {k.row, k.col} = {4'd3, 3'd1};  9'h16B: {k.row, k.col} = {4'd3, 3'd0};
            9'h01D: {k.row, k.col} = {4'd4, 3'd5};  9'h03A: {k.row, k.col} = {4'd4, 3'd4};
            9'h021: {k.row, k.col} = {4'd4, 3'd3};  9'h046: {k.row, k.col} = {4'd4, 3'd2};
            9'h066: {k.row, k.col} = {4'd4, 3'd1};  9'h058: {k.row, k.col} = {4'd4, 3'd0};
            9'h02A: {k.row, k.col} = {4'd5, 3'd5};  9'h04B: {k.row, k.col} = {4'd5, 3'd4};
            9'h032: {k.row, k.col} = {4'd5, 3'd3};  9'h03E: {k.row, k.col} = {4'd5, 3'd2};
            9'h169: {k.row, k.col} = {4'd5, 3'd1};  9'h055: {k.row, k.col} = {4'd5, 3'd0};
            9'h03C: {k.row, k.col} = {4'd6, 3'd5};  9'h042: {k.row, k.col} = {4'd6, 3'd4};
            9'h02B: {k.row, k.col} = {4'd6, 3'd3};  9'h03D: {k.row, k.col} = {4'd6, 3'd2};
            9'h05A: {k.row, k.col} = {4'd6, 3'd1};  9'h054: {k.row, k.col} = {4'd6, 3'd0};
            9'h02C: {k.row, k.col} = {4'd7, 3'd5};  9'h03B: {k.row, k.col} = {4'd7, 3'd4};
            9'h033: {k.row, k.col} = {4'd7, 3'd3};  9'h036: {k.row, k.col} = {4'd7, 3'd2};
            9'h049: {k.row, k.col} = {4'd7, 3'd1};  9'h05D: {k.row, k.col} = {4'd7, 3'd0};
            9'h01B: {k.row, k.col} = {4'd8, 3'd5};  9'h043: {k.row, k.col} = {4'd8, 3'd4};
            9'h02D: {k.row, k.col} = {4'd8, 3'd3};  9'h02E: {k.row, k.col} = {4'd8, 3'd2};
            9'h04A: {k.row, k.col} = {4'd8, 3'd1};  9'h05B: {k.row, k.col} = {4'd8, 3'd0};
            9'h025: {k.row, k.col} = {4'd9, 3'd5};  9'h00E: {k.row, k.col} = {4'd9, 3'd4};
            9'h029: {k.row, k.col} = {4'd9, 3'd0};
            default: k.kind = K_NONE;
        endcase
        return k;
    endfunction

    // ---------------- decoder and key state ----------------
    logic [5:0] matrix_q [0:9];
    logic       brk_q, ext_q, shift_key_q, ctrl_key_q, rept_key_q;
    key_t       key;

    assign key = kbd_map({ext_q, byte_q});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the matrix is a handful of flops that must read "no key"
            // straight out of reset, so it is reset rather than treated as RAM.
            for (int r = 0; r < 10; r++) matrix_q[r] <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            shift_key_q <= 1'b0;
            ctrl_key_q  <= 1'b0;
            rept_key_q  <= 1'b0;
        end else if (byte_valid_q) begin
            if (byte_q == 8'hF0) begin
                brk_q <= 1'b1;
            end else if (byte_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else begin
                case (key.kind)
                    K_MATRIX: matrix_q[key.row][key.col] <= !brk_q;
                    K_SHIFT:  shift_key_q <= !brk_q;
                    K_CTRL:   ctrl_key_q  <= !brk_q;
                    K_REPT:   rept_key_q  <= !brk_q;
                    default:  ;
                endcase
                brk_q <= 1'b0;
                ext_q <= 1'b0;
            end
        end
    end

`ifdef ATOM_KBD_BREAK_EN
    logic break_key_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            break_key_q <= 1'b0;
        else if (byte_valid_q && byte_q != 8'hF0 && byte_q != 8'hE0 && key.kind == K_BREAK)
            break_key_q <= !brk_q;
    end

    assign break_n = ~break_key_q;
`else
    assign break_n = 1'b1;
`endif

    // Combinational read of registered state: a row change is visible at once.
    assign keyboard  = (row > 4'd9) ? 6'h3F : ~matrix_q[row];
    assign shift_n   = ~shift_key_q;
    assign ctrl_n    = ~ctrl_key_q;
    assign rept_n    = ~rept_key_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_atom_ps2_keyboard.sv
// tb_atom_ps2_keyboard
//   Directed scan-code frames into atom_ps2_keyboard. Stimulus pushes expected
//   output snapshots and expected frame_err pulses into queues; a monitor on the
//   falling clock edge pops and compares them.

module tb_atom_ps2_keyboard;
    localparam int HALF        = 20;     // PS/2 half bit period in clk cycles
    localparam int TIMEOUT_CYC = 5000;   // 200 us at 25 MHz

`ifdef ATOM_KBD_BREAK_EN
    localparam logic BK_MAKE = 1'b0;
`else
    localparam logic BK_MAKE = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] row = 4'd0;
    logic [5:0] keyboard;
    logic       shift_n, ctrl_n, rept_n, frame_err, break_n;

    int tests = 0;
    int fails = 0;

    string      err_q[$];
    string      name_q[$];
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    atom_ps2_keyboard dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .row       (row),
        .keyboard  (keyboard),
        .shift_n   (shift_n),
        .ctrl_n    (ctrl_n),
        .rept_n    (rept_n),
        .frame_err (frame_err),
        .break_n   (break_n)
    );

    // ---------------- monitor ----------------
    initial begin
        string      nm;
        logic [9:0] ex, act;
        forever begin
            @(negedge clk);
            if (frame_err) begin
                tests++;
                if (err_q.size() == 0) begin
                    fails++;
                    $display("FAIL frame_err: unexpected pulse, got 1 required 0");
                end else begin
                    void'(err_q.pop_front());
                end
            end
            if (exp_q.size() > 0) begin
                nm  = name_q.pop_front();
                ex  = exp_q.pop_front();
                act = {keyboard, shift_n, ctrl_n, rept_n, break_n};
                tests++;
                if (act !== ex) begin
                    fails++;
                    $display("FAIL %s: got kbd=%h sh/ct/rp/bk=%b%b%b%b required kbd=%h sh/ct/rp/bk=%b%b%b%b",
                             nm, act[9:4], act[3], act[2], act[1], act[0],
                             ex[9:4], ex[3], ex[2], ex[1], ex[0]);
                end
            end
        end
    end

    initial begin
        #(900000);
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] code, input logic bad_par);
        return {1'b1, (~^code) ^ bad_par, code, 1'b0};
    endfunction

    task automatic send(input logic [7:0] code, input logic bad_par = 1'b0);
        logic [10:0] f;
        f = frame(code, bad_par);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        cyc(40);
    endtask

    task automatic partial(input logic [7:0] code, input int nbits);
        logic [10:0] f;
        f = frame(code, 1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic expect_out(input string nm, input logic [3:0] r, input logic [5:0] kb,
                              input logic sh = 1'b1, input logic ct = 1'b1,
                              input logic rp = 1'b1, input logic bk = 1'b1);
        row = r;
        name_q.push_back(nm);
        exp_q.push_back({kb, sh, ct, rp, bk});
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) cyc(1);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL %s: monitor did not sample, got pending required sampled", nm);
            name_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic wait_err(input string nm);
        for (int i = 0; i < 200 && err_q.size() > 0; i++) cyc(1);
        if (err_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL %s: frame_err never pulsed, got 0 required 1", nm);
            err_q.delete();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        cyc(5);
        expect_out("in_reset", 4'd0, 6'h3F);
        reset_n = 1'b1;
        cyc(20);
        expect_out("reset_row0", 4'd0, 6'h3F);

        // A make / break, row isolation
        send(8'h1C);
        expect_out("a_make_row1", 4'd1, 6'h37);
        expect_out("a_make_row2", 4'd2, 6'h3F);
        send(8'hF0); send(8'h1C);
        expect_out("a_break_row1", 4'd1, 6'h3F);
        expect_out("a_break_row2", 4'd2, 6'h3F);

        // shift held around A
        send(8'h12);
        expect_out("shift_held", 4'd1, 6'h3F, 1'b0);
        send(8'h1C);
        expect_out("a_with_shift", 4'd1, 6'h37, 1'b0);
        send(8'hF0); send(8'h12);
        expect_out("shift_released", 4'd1, 6'h37);
        send(8'hF0); send(8'h1C);
        expect_out("a_released", 4'd1, 6'h3F);

        // bad parity, then good SPACE, repeated make
        err_q.push_back("parity");
        send(8'h29, 1'b1);
        wait_err("parity");
        expect_out("bad_parity_row9", 4'd9, 6'h3F);
        send(8'h29);
        expect_out("space_make", 4'd9, 6'h3E);
        send(8'h29);
        expect_out("space_repeat", 4'd9, 6'h3E);
        send(8'hF0); send(8'h29);
        expect_out("space_break", 4'd9, 6'h3F);

        // timeout mid-frame, then RETURN
        err_q.push_back("timeout");
        partial(8'h5A, 5);
        cyc(TIMEOUT_CYC + 10);
        wait_err("timeout");
        expect_out("after_timeout_row6", 4'd6, 6'h3F);
        send(8'h5A);
        expect_out("return_row6", 4'd6, 6'h3D);
        expect_out("row14_idle", 4'd14, 6'h3F);
        expect_out("row10_idle", 4'd10, 6'h3F);

        // extended prefix selects a different key
        send(8'h75);
        expect_out("kp8_unmapped", 4'd2, 6'h3F);
        send(8'hE0); send(8'h75);
        expect_out("up_make", 4'd2, 6'h3E);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_out("up_break", 4'd2, 6'h3F);

        // ctrl: extended make, plain break
        send(8'hE0); send(8'h14);
        expect_out("rctrl_make", 4'd6, 6'h3D, 1'b1, 1'b0);
        send(8'hF0); send(8'h14);
        expect_out("ctrl_break", 4'd6, 6'h3D);
        send(8'h11);
        expect_out("rept_make", 4'd6, 6'h3D, 1'b1, 1'b1, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h11);
        expect_out("rept_break", 4'd6, 6'h3D);

        // F12 / BREAK
        send(8'h07);
        expect_out("f12_make", 4'd6, 6'h3D, 1'b1, 1'b1, 1'b1, BK_MAKE);
        send(8'hF0); send(8'h07);
        expect_out("f12_break", 4'd6, 6'h3D);

        // unmapped code clears a pending break prefix
        send(8'hF0); send(8'h05); send(8'h1C);
        expect_out("unmapped_clears_brk", 4'd1, 6'h37);

        // short ps2_clk glitches with data low must not start a frame
        ps2_data = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2_clk = 1'b0;
            cyc(4);
            ps2_clk = 1'b1;
            cyc(20);
        end
        ps2_data = 1'b1;
        cyc(20);
        send(8'hF0); send(8'h1C);
        expect_out("after_glitch_a_break", 4'd1, 6'h3F);
        send(8'h2C);
        expect_out("t_make_row7", 4'd7, 6'h1F);

        // reset in the middle of a frame
        send(8'h12);
        expect_out("pre_reset_shift", 4'd7, 6'h1F, 1'b0);
        partial(8'h1C, 4);
        ps2_data = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(12);
        reset_n = 1'b0;
        cyc(2);
        expect_out("reset_mid_frame", 4'd7, 6'h3F);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cyc(5);
        reset_n = 1'b1;
        cyc(20);
        expect_out("post_reset_row6", 4'd6, 6'h3F);
        send(8'h5A);
        expect_out("post_reset_return", 4'd6, 6'h3D);
        expect_out("post_reset_row7", 4'd7, 6'h3F);

        cyc(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
